// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider for DIV/DIVU, one quotient bit per cycle, HI=remainder LO=quotient
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               sgn_q, sgn_d;
  logic               na_q, na_d;
  logic               nb_q, nb_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     part, diff;
  logic               ge;
  logic [2*WIDTH-1:0] step;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               abort;
  // Datapath: operand magnitudes, one restoring step over {rem, dividend} and the final sign fix
  always_comb begin
    abs_a   = (signed_i & opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    abs_b   = (signed_i & opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    part    = work_q[2*WIDTH-1:WIDTH-1];
    diff    = part - {1'b0, dvs_q};
    ge      = part >= {1'b0, dvs_q};
    step    = {ge ? diff[WIDTH-1:0] : part[WIDTH-1:0], work_q[WIDTH-2:0], ge};
    quo_fix = (sgn_q & (na_q ^ nb_q)) ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    rem_fix = (sgn_q & na_q) ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
    abort   = annul_i | ~start_i;
  end
  // Next-state logic: FREE accepts, ON iterates WIDTH steps, END holds the result until start drops
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    dvs_d    = dvs_q;
    sgn_d    = sgn_q;
    na_d     = na_q;
    nb_d     = nb_q;
    result_d = result_q;
    unique case (state_q)
      S_FREE: begin
        result_d = '0;
        if (!abort) begin
          state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
          cnt_d   = '0;
          work_d  = {{WIDTH{1'b0}}, abs_a};
          dvs_d   = abs_b;
          sgn_d   = signed_i;
          na_d    = opdata1_i[WIDTH-1];
          nb_d    = opdata2_i[WIDTH-1];
        end
      end
      S_BYZERO: begin
        result_d = '0;
        state_d  = abort ? S_FREE : S_END;
      end
      S_ON: begin
        if (abort) begin
          state_d  = S_FREE;
          result_d = '0;
        end else begin
          work_d = step;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d  = S_END;
            result_d = {rem_fix, quo_fix};
          end
        end
      end
      S_END: begin
        if (abort) begin
          state_d  = S_FREE;
          result_d = '0;
        end
      end
      default: state_d = S_FREE;
    endcase
  end
  // State and datapath registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      work_q   <= '0;
      dvs_q    <= '0;
      sgn_q    <= 1'b0;
      na_q     <= 1'b0;
      nb_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dvs_q    <= dvs_d;
      sgn_q    <= sgn_d;
      na_q     <= na_d;
      nb_q     <= nb_d;
      result_q <= result_d;
    end
  end
  assign result_o = result_q;
  assign ready_o  = state_q == S_END;
  assign busy_o   = start_i & ~ready_o;
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed tests of div_seq with hand-computed quotient/remainder and latency
module tb_div_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [63:0] res;
  int          lat;
  always #5 clk = ~clk;
  div_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i), .signed_i(signed_i),
    .opdata1_i(a), .opdata2_i(b), .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_op(input logic sg, input logic [31:0] x, input logic [31:0] y,
                       output logic [63:0] r, output int l);
    signed_i = sg;
    a        = x;
    b        = y;
    start_i  = 1'b1;
    l        = -1;
    r        = '0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (ready_o) begin
        l = c;
        r = result_o;
        break;
      end
    end
    start_i = 1'b0;
    tick();
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total_cnt++; if (ready_o !== 1'b0) $display("FAIL reset_ready got %b want 0", ready_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else pass_cnt++;
    total_cnt++; if (result_o !== 64'h0) $display("FAIL reset_result got %h want 0", result_o); else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask
  task automatic test_divu_basic();
    int bad = 0;
    signed_i = 1'b0;
    a        = 32'd100;
    b        = 32'd7;
    start_i  = 1'b1;
    #1;
    total_cnt++; if (busy_o !== 1'b1) $display("FAIL divu_busy_c0 got %b want 1", busy_o); else pass_cnt++;
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (ready_o !== 1'b0 || busy_o !== 1'b1) bad++;
    end
    total_cnt++; if (bad != 0) $display("FAIL divu_busy_window got %0d bad cycles want 0", bad); else pass_cnt++;
    tick();
    total_cnt++; if (ready_o !== 1'b1) $display("FAIL divu_ready_c33 got %b want 1", ready_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL divu_busy_c33 got %b want 0", busy_o); else pass_cnt++;
    total_cnt++; if (result_o !== {32'd2, 32'd14}) $display("FAIL divu_100_7 got %h want %h", result_o, {32'd2, 32'd14}); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (ready_o !== 1'b1 || result_o !== {32'd2, 32'd14}) $display("FAIL divu_hold got ready=%b res=%h want ready=1 res=%h", ready_o, result_o, {32'd2, 32'd14}); else pass_cnt++;
    start_i = 1'b0;
    tick();
    total_cnt++; if (ready_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL divu_release got ready=%b busy=%b want 0 0", ready_o, busy_o); else pass_cnt++;
    total_cnt++; if (result_o !== 64'h0) $display("FAIL divu_release_result got %h want 0", result_o); else pass_cnt++;
  endtask
  task automatic test_signed();
    do_op(1'b1, 32'hFFFFFFF9, 32'h2, res, lat);
    total_cnt++; if (res !== 64'hFFFFFFFF_FFFFFFFD) $display("FAIL div_m7_2 got %h want FFFFFFFFFFFFFFFD", res); else pass_cnt++;
    total_cnt++; if (lat != 33) $display("FAIL div_m7_2_latency got %0d want 33", lat); else pass_cnt++;
    do_op(1'b1, 32'h7, 32'hFFFFFFFE, res, lat);
    total_cnt++; if (res !== 64'h00000001_FFFFFFFD) $display("FAIL div_7_m2 got %h want 00000001FFFFFFFD", res); else pass_cnt++;
    do_op(1'b0, 32'hFFFFFFF9, 32'h2, res, lat);
    total_cnt++; if (res !== 64'h00000001_7FFFFFFC) $display("FAIL divu_fff9_2 got %h want 000000017FFFFFFC", res); else pass_cnt++;
  endtask
  task automatic test_overflow();
    do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, res, lat);
    total_cnt++; if (res !== 64'h00000000_80000000) $display("FAIL div_minint_m1 got %h want 0000000080000000", res); else pass_cnt++;
    do_op(1'b0, 32'hFFFFFFFF, 32'h1, res, lat);
    total_cnt++; if (res !== 64'h00000000_FFFFFFFF) $display("FAIL divu_max_1 got %h want 00000000FFFFFFFF", res); else pass_cnt++;
  endtask
  task automatic test_byzero();
    do_op(1'b0, 32'd5, 32'd0, res, lat);
    total_cnt++; if (lat != 2) $display("FAIL byzero_latency got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (res !== 64'h0) $display("FAIL byzero_result got %h want 0", res); else pass_cnt++;
  endtask
  task automatic test_annul();
    logic seen = 1'b0;
    signed_i = 1'b0;
    a        = 32'd100;
    b        = 32'd7;
    start_i  = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      seen |= ready_o;
    end
    annul_i = 1'b1;
    tick();
    seen |= ready_o;
    total_cnt++; if (seen !== 1'b0 || result_o !== 64'h0) $display("FAIL annul_abort got seen=%b res=%h want 0 0", seen, result_o); else pass_cnt++;
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();
    do_op(1'b0, 32'd9, 32'd3, res, lat);
    total_cnt++; if (lat != 33 || res !== {32'd0, 32'd3}) $display("FAIL annul_next_op got lat=%0d res=%h want 33 %h", lat, res, {32'd0, 32'd3}); else pass_cnt++;
    a       = 32'd100;
    b       = 32'd7;
    start_i = 1'b1;
    repeat (10) tick();
    annul_i = 1'b1;
    a       = 32'd9;
    b       = 32'd3;
    tick();
    annul_i = 1'b0;
    do_op(1'b0, 32'd9, 32'd3, res, lat);
    total_cnt++; if (lat != 33 || res !== {32'd0, 32'd3}) $display("FAIL annul_start_held got lat=%0d res=%h want 33 %h", lat, res, {32'd0, 32'd3}); else pass_cnt++;
  endtask
  task automatic test_rst_mid();
    signed_i = 1'b0;
    a        = 32'd100;
    b        = 32'd7;
    start_i  = 1'b1;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    total_cnt++; if (ready_o !== 1'b0 || result_o !== 64'h0) $display("FAIL rst_mid got ready=%b res=%h want 0 0", ready_o, result_o); else pass_cnt++;
    rst = 1'b0;
    do_op(1'b0, 32'd9, 32'd3, res, lat);
    total_cnt++; if (lat != 33 || res !== {32'd0, 32'd3}) $display("FAIL rst_mid_restart got lat=%0d res=%h want 33 %h", lat, res, {32'd0, 32'd3}); else pass_cnt++;
  endtask
  task automatic test_start_annul();
    int bad = 0;
    signed_i = 1'b0;
    a        = 32'd9;
    b        = 32'd3;
    start_i  = 1'b1;
    annul_i  = 1'b1;
    repeat (3) begin
      tick();
      if (ready_o !== 1'b0) bad++;
    end
    annul_i = 1'b0;
    do_op(1'b0, 32'd20, 32'd6, res, lat);
    total_cnt++; if (bad != 0 || lat != 33) $display("FAIL start_annul_free got bad=%0d lat=%0d want 0 33", bad, lat); else pass_cnt++;
    total_cnt++; if (res !== {32'd2, 32'd3}) $display("FAIL start_annul_result got %h want %h", res, {32'd2, 32'd3}); else pass_cnt++;
  endtask
  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_overflow();
    test_byzero();
    test_annul();
    test_rst_mid();
    test_start_annul();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
